// File: rtl/game_controller.sv
// Memory game round controller: shows an LFSR-derived BCD target,
// collects four user digits, then reports the result and streak.
module game_controller #(
  parameter int          SHOW_TICKS   = 8,
  parameter int          RESULT_TICKS = 8,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        startBtn,
  input  logic        blinkTick,
  input  logic        digitValid,
  input  logic [3:0]  digitIn,
  output logic        displayPhase,
  output logic [15:0] randInt,
  output logic [15:0] userInput,
  output logic        inputReady,
  output logic        correct,
  output logic [7:0]  streak
);

  localparam int MAXT = (SHOW_TICKS > RESULT_TICKS) ?
                        SHOW_TICKS : RESULT_TICKS;
  localparam int CW   = (MAXT > 1) ? $clog2(MAXT) : 1;

  localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_TICKS - 1);
  localparam logic [CW-1:0] RES_LAST  = CW'(RESULT_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHOW,
    S_INPUT,
    S_RESULT
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_tick;
  logic [CW-1:0] w_tick_nxt;
  logic [1:0]    r_dcnt;
  logic [1:0]    w_dcnt_nxt;
  logic [15:0]   r_lfsr;
  logic [15:0]   w_lfsr_nxt;
  logic          w_fb;
  logic [15:0]   w_target;
  logic [15:0]   w_shift;
  logic          w_digit_ok;

  logic          r_disp;
  logic          w_disp_nxt;
  logic [15:0]   r_rand;
  logic [15:0]   w_rand_nxt;
  logic [15:0]   r_user;
  logic [15:0]   w_user_nxt;
  logic          r_ready;
  logic          w_ready_nxt;
  logic          r_correct;
  logic          w_correct_nxt;
  logic [7:0]    r_streak;
  logic [7:0]    w_streak_nxt;

  // Fold a raw nibble into a decimal digit (10..15 -> 0..5).
  function automatic logic [3:0] f_bcd(input logic [3:0] n);
    f_bcd = (n > 4'd9) ? (n - 4'd10) : n;
  endfunction

  // Fibonacci LFSR for x^16+x^14+x^13+x^11+1, shifting right.
  always_comb begin
    w_fb       = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    w_lfsr_nxt = {w_fb, r_lfsr[15:1]};
  end

  // Candidate target and the user value after one more digit.
  always_comb begin
    w_target   = {f_bcd(r_lfsr[15:12]), f_bcd(r_lfsr[11:8]),
                  f_bcd(r_lfsr[7:4]),   f_bcd(r_lfsr[3:0])};
    w_shift    = {r_user[11:0], digitIn};
    w_digit_ok = digitValid && (digitIn <= 4'd9);
  end

  // Next-state and registered-output logic for the round FSM.
  always_comb begin
    w_state_nxt   = r_state;
    w_tick_nxt    = r_tick;
    w_dcnt_nxt    = r_dcnt;
    w_disp_nxt    = r_disp;
    w_rand_nxt    = r_rand;
    w_user_nxt    = r_user;
    w_ready_nxt   = r_ready;
    w_correct_nxt = r_correct;
    w_streak_nxt  = r_streak;
    unique case (r_state)
      S_IDLE: begin
        if (startBtn) begin
          w_state_nxt = S_SHOW;
          w_rand_nxt  = w_target;
          w_tick_nxt  = '0;
          w_disp_nxt  = 1'b1;
        end
      end
      S_SHOW: begin
        if (blinkTick) begin
          if (r_tick == SHOW_LAST) begin
            w_state_nxt = S_INPUT;
            w_disp_nxt  = 1'b0;
            w_user_nxt  = '0;
            w_dcnt_nxt  = '0;
            w_tick_nxt  = '0;
          end else begin
            w_tick_nxt = r_tick + CW'(1);
          end
        end
      end
      S_INPUT: begin
        if (w_digit_ok) begin
          w_user_nxt = w_shift;
          if (r_dcnt == 2'd3) begin
            w_state_nxt   = S_RESULT;
            w_dcnt_nxt    = '0;
            w_tick_nxt    = '0;
            w_ready_nxt   = 1'b1;
            w_correct_nxt = (w_shift == r_rand);
            if (w_shift == r_rand) begin
              w_streak_nxt = (r_streak == 8'hFF) ?
                             8'hFF : (r_streak + 8'd1);
            end else begin
              w_streak_nxt = '0;
            end
          end else begin
            w_dcnt_nxt = r_dcnt + 2'd1;
          end
        end
      end
      S_RESULT: begin
        // A restart beats a simultaneous final tick.
        if (startBtn) begin
          w_state_nxt   = S_SHOW;
          w_rand_nxt    = w_target;
          w_tick_nxt    = '0;
          w_disp_nxt    = 1'b1;
          w_ready_nxt   = 1'b0;
          w_correct_nxt = 1'b0;
          w_user_nxt    = '0;
        end else if (blinkTick) begin
          if (r_tick == RES_LAST) begin
            w_state_nxt   = S_IDLE;
            w_tick_nxt    = '0;
            w_ready_nxt   = 1'b0;
            w_correct_nxt = 1'b0;
            w_user_nxt    = '0;
          end else begin
            w_tick_nxt = r_tick + CW'(1);
          end
        end
      end
    endcase
  end

  // State, counters, LFSR and outputs; reset discards the round.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_tick    <= '0;
      r_dcnt    <= '0;
      r_lfsr    <= LFSR_SEED;
      r_disp    <= 1'b0;
      r_rand    <= '0;
      r_user    <= '0;
      r_ready   <= 1'b0;
      r_correct <= 1'b0;
      r_streak  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_tick    <= w_tick_nxt;
      r_dcnt    <= w_dcnt_nxt;
      r_lfsr    <= w_lfsr_nxt;
      r_disp    <= w_disp_nxt;
      r_rand    <= w_rand_nxt;
      r_user    <= w_user_nxt;
      r_ready   <= w_ready_nxt;
      r_correct <= w_correct_nxt;
      r_streak  <= w_streak_nxt;
    end
  end

  assign displayPhase = r_disp;
  assign randInt      = r_rand;
  assign userInput    = r_user;
  assign inputReady   = r_ready;
  assign correct      = r_correct;
  assign streak       = r_streak;

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: directed vectors, corner sequences
// and random stimulus against a round-level reference model.
module tb_game_controller;

  localparam int          ST   = 8;
  localparam int          RT   = 8;
  localparam logic [15:0] SEED = 16'hACE1;

  localparam int P_IDLE   = 0;
  localparam int P_SHOW   = 1;
  localparam int P_INPUT  = 2;
  localparam int P_RESULT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        startBtn;
  logic        blinkTick;
  logic        digitValid;
  logic [3:0]  digitIn;
  logic        displayPhase;
  logic [15:0] randInt;
  logic [15:0] userInput;
  logic        inputReady;
  logic        correct;
  logic [7:0]  streak;

  always #5 clk = ~clk;

  game_controller #(
    .SHOW_TICKS  (ST),
    .RESULT_TICKS(RT),
    .LFSR_SEED   (SEED)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .startBtn    (startBtn),
    .blinkTick   (blinkTick),
    .digitValid  (digitValid),
    .digitIn     (digitIn),
    .displayPhase(displayPhase),
    .randInt     (randInt),
    .userInput   (userInput),
    .inputReady  (inputReady),
    .correct     (correct),
    .streak      (streak)
  );

  int total = 0;
  int bad   = 0;

  int          m_phase;
  int          m_left;
  logic [15:0] m_lfsr;
  logic [15:0] m_rand;
  logic        m_correct;
  int          m_streak;
  int          m_q[$];

  typedef struct {
    logic        dv;
    logic [3:0]  din;
    logic        st;
    logic [15:0] user;
    logic        ready;
    logic        corr;
    logic [7:0]  strk;
  } vec_t;

  vec_t vt[7];

  // Taps at 16,14,13,11 are bits 0,2,3,5 of a right-shifting register.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic b;
    b = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {b, s[15:1]};
  endfunction

  function automatic logic [15:0] to_bcd(input logic [15:0] v);
    int r;
    int n;
    r = 0;
    for (int i = 0; i < 4; i++) begin
      n = (int'(v) >> (4 * i)) & 15;
      r = r | ((n % 10) << (4 * i));
    end
    return 16'(r);
  endfunction

  function automatic int user_val();
    int u;
    u = 0;
    foreach (m_q[i]) u = ((u << 4) | m_q[i]) & 16'hFFFF;
    return u;
  endfunction

  task automatic begin_round(input logic [15:0] cur);
    m_rand    = to_bcd(cur);
    m_left    = ST;
    m_phase   = P_SHOW;
    m_correct = 1'b0;
    m_q.delete();
  endtask

  task automatic model(input logic r, input logic s, input logic t,
                       input logic v, input logic [3:0] d);
    logic [15:0] cur;
    if (r) begin
      m_phase   = P_IDLE;
      m_left    = 0;
      m_lfsr    = SEED;
      m_rand    = '0;
      m_correct = 1'b0;
      m_streak  = 0;
      m_q.delete();
      return;
    end
    cur    = m_lfsr;
    m_lfsr = lfsr_next(m_lfsr);
    case (m_phase)
      P_IDLE: if (s) begin_round(cur);
      P_SHOW: begin
        if (t) begin
          m_left--;
          if (m_left == 0) begin
            m_phase = P_INPUT;
            m_q.delete();
          end
        end
      end
      P_INPUT: begin
        if (v && d <= 4'd9) begin
          m_q.push_back(int'(d));
          if (m_q.size() == 4) begin
            m_phase   = P_RESULT;
            m_correct = (user_val() == int'(m_rand));
            m_streak  = m_correct ?
                        ((m_streak >= 255) ? 255 : m_streak + 1) : 0;
            m_left    = RT;
          end
        end
      end
      default: begin
        if (s) begin
          begin_round(cur);
        end else if (t) begin
          m_left--;
          if (m_left == 0) begin
            m_phase   = P_IDLE;
            m_correct = 1'b0;
            m_q.delete();
          end
        end
      end
    endcase
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  task automatic check_model();
    chk("m_disp",    int'(displayPhase), int'(m_phase == P_SHOW));
    chk("m_ready",   int'(inputReady),   int'(m_phase == P_RESULT));
    chk("m_rand",    int'(randInt),      int'(m_rand));
    chk("m_user",    int'(userInput),    user_val());
    chk("m_correct", int'(correct),      int'(m_correct));
    chk("m_streak",  int'(streak),       m_streak);
  endtask

  task automatic step(input logic r, input logic s, input logic t,
                      input logic v, input logic [3:0] d);
    rst        = r;
    startBtn   = s;
    blinkTick  = t;
    digitValid = v;
    digitIn    = d;
    model(r, s, t, v, d);
    @(posedge clk);
    @(negedge clk);
    rst        = 1'b0;
    startBtn   = 1'b0;
    blinkTick  = 1'b0;
    digitValid = 1'b0;
    digitIn    = 4'd0;
    check_model();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1, 0, 4'd0);
  endtask

  function automatic logic [3:0] want_digit();
    int sh;
    sh = 4 * (3 - m_q.size());
    return 4'((int'(m_rand) >> sh) & 15);
  endfunction

  initial begin
    logic [3:0] d;
    logic       s;
    logic       t;
    logic       v;
    logic       r;

    vt[0] = '{1'b1, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'd0};
    vt[1] = '{1'b1, 4'hB, 1'b0, 16'h0000, 1'b0, 1'b0, 8'd0};
    vt[2] = '{1'b0, 4'h5, 1'b1, 16'h0000, 1'b0, 1'b0, 8'd0};
    vt[3] = '{1'b1, 4'h2, 1'b0, 16'h0002, 1'b0, 1'b0, 8'd0};
    vt[4] = '{1'b1, 4'h4, 1'b0, 16'h0024, 1'b0, 1'b0, 8'd0};
    vt[5] = '{1'b0, 4'h7, 1'b0, 16'h0024, 1'b0, 1'b0, 8'd0};
    vt[6] = '{1'b1, 4'h1, 1'b0, 16'h0241, 1'b1, 1'b1, 8'd1};

    step(1, 0, 0, 0, 4'd0);
    step(1, 1, 1, 1, 4'd3);
    chk("rst_disp",   int'(displayPhase), 0);
    chk("rst_rand",   int'(randInt),      0);
    chk("rst_user",   int'(userInput),    0);
    chk("rst_ready",  int'(inputReady),   0);
    chk("rst_streak", int'(streak),       0);

    step(0, 1, 0, 0, 4'd0);
    chk("first_rand", int'(randInt),      16'h0241);
    chk("first_disp", int'(displayPhase), 1);

    for (int i = 0; i < 7; i++) begin
      step(0, 0, 1, 0, 4'd0);
      step(0, 1, 0, 1, 4'd5);
    end
    chk("show_7", int'(displayPhase), 1);
    step(0, 0, 1, 0, 4'd0);
    chk("show_8", int'(displayPhase), 0);

    foreach (vt[i]) begin
      step(0, vt[i].st, 1'b0, vt[i].dv, vt[i].din);
      chk($sformatf("vec%0d_user", i),  int'(userInput),
          int'(vt[i].user));
      chk($sformatf("vec%0d_ready", i), int'(inputReady),
          int'(vt[i].ready));
      chk($sformatf("vec%0d_corr", i),  int'(correct),
          int'(vt[i].corr));
      chk($sformatf("vec%0d_strk", i),  int'(streak),
          int'(vt[i].strk));
      chk($sformatf("vec%0d_disp", i),  int'(displayPhase), 0);
      chk($sformatf("vec%0d_rand", i),  int'(randInt), 16'h0241);
    end

    step(0, 1, 0, 0, 4'd0);
    chk("restart_disp",  int'(displayPhase), 1);
    chk("restart_ready", int'(inputReady),   0);
    ticks(ST);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 4'd9);
    chk("r2_ready", int'(inputReady), 1);
    chk("r2_corr",  int'(correct), int'(randInt == 16'h9999));
    chk("r2_strk",  int'(streak),
        (randInt == 16'h9999) ? 2 : 0);

    ticks(RT - 1);
    chk("res_hold", int'(inputReady), 1);
    step(0, 1, 1, 0, 4'd0);
    chk("race_disp",  int'(displayPhase), 1);
    chk("race_ready", int'(inputReady),   0);

    ticks(ST);
    step(0, 0, 0, 1, 4'd1);
    step(0, 0, 0, 1, 4'd2);
    chk("mid_user", int'(userInput), 16'h0012);
    step(1, 0, 0, 1, 4'd3);
    chk("mid_disp",  int'(displayPhase), 0);
    chk("mid_ready", int'(inputReady),   0);
    chk("mid_corr",  int'(correct),      0);
    chk("mid_rand",  int'(randInt),      0);
    chk("mid_user0", int'(userInput),    0);
    chk("mid_strk",  int'(streak),       0);
    step(0, 1, 0, 0, 4'd0);
    chk("reload_rand", int'(randInt), 16'h0241);

    for (int i = 0; i < 260; i++) begin
      ticks(ST);
      for (int k = 0; k < 4; k++) step(0, 0, 0, 1, want_digit());
      chk("sat_strk", int'(streak), (i + 1 > 255) ? 255 : i + 1);
      step(0, 1, 0, 0, 4'd0);
    end

    for (int i = 0; i < 5000; i++) begin
      r = ($urandom_range(399) == 0);
      s = ($urandom_range(24) == 0);
      t = ($urandom_range(2) == 0);
      v = ($urandom_range(1) == 0);
      d = 4'($urandom_range(15));
      if (m_phase == P_INPUT && $urandom_range(3) != 0)
        d = want_digit();
      step(r, s, t, v, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
